// File: rtl/mul_share_arbiter_if.sv
// Handshake/result bundle between two requesters and the shared-multiplier arbiter.
// The master modport is the requester side; the slave modport is the arbiter.
interface mul_share_arbiter_if;
  logic       req0;
  logic [7:0] a0;
  logic [7:0] b0;
  logic       req1;
  logic [7:0] a1;
  logic [7:0] b1;
  logic       ack0;
  logic       ack1;
  logic       done0;
  logic       done1;
  logic [7:0] r;
  logic       ovf;
  logic       busy;
  logic       grant_id;

  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  ack0, ack1, done0, done1, r, ovf, busy, grant_id
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output ack0, ack1, done0, done1, r, ovf, busy, grant_id
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin time-sharing of one combinational signed 8x8 multiplier between two
// requesters: latch the winner's operands, let them settle WAIT_CYCLES, then return the result.

module mul_signed (
  input  logic signed [7:0] i_a,
  input  logic signed [7:0] i_b,
  output logic        [7:0] o_r,
  output logic              o_ovf
);
  logic signed [15:0] w_a_ext;
  logic signed [15:0] w_b_ext;
  logic signed [15:0] w_full;

  assign w_a_ext = {{8{i_a[7]}}, i_a};
  assign w_b_ext = {{8{i_b[7]}}, i_b};
  assign w_full  = w_a_ext * w_b_ext;
  assign o_r     = w_full[7:0];
  // Product fits in 8 signed bits only if bits 15..7 are a pure sign extension.
  assign o_ovf   = (w_full[15:7] != {9{w_full[7]}});
endmodule

module mul_share_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mul_share_arbiter_if.slave   bus
);
  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic       w_grant;
  logic       w_win;
  logic       w_capture;

  logic [7:0] r_op_a;
  logic [7:0] r_op_b;
  logic [3:0] r_cnt;
  logic       r_last_grant;
  logic       r_grant_id;
  logic [7:0] r_r;
  logic       r_ovf;
  logic       r_ack0;
  logic       r_ack1;
  logic       r_done0;
  logic       r_done1;
  logic [7:0] w_mul_r;
  logic       w_mul_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Requests are only looked at in IDLE; on a tie the one not served last wins.
  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_win        = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          w_grant      = 1'b1;
          w_win        = (bus.req0 && bus.req1) ? ~r_last_grant : bus.req1;
          w_state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (r_cnt == 4'd1) begin
          w_capture    = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a       <= 8'd0;
      r_op_b       <= 8'd0;
      r_cnt        <= 4'd0;
      r_last_grant <= 1'b1;
      r_grant_id   <= 1'b0;
      r_r          <= 8'd0;
      r_ovf        <= 1'b0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
    end else begin
      r_ack0  <= w_grant & ~w_win;
      r_ack1  <= w_grant & w_win;
      r_done0 <= w_capture & ~r_grant_id;
      r_done1 <= w_capture & r_grant_id;
      if (w_grant) begin
        r_op_a       <= w_win ? bus.a1 : bus.a0;
        r_op_b       <= w_win ? bus.b1 : bus.b0;
        r_grant_id   <= w_win;
        r_last_grant <= w_win;
        r_cnt        <= LP_WAIT;
      end else if (r_state == S_EXEC) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_capture) begin
        r_r   <= w_mul_r;
        r_ovf <= w_mul_ovf;
      end
    end
  end

  mul_signed u_mul (
    .i_a   (r_op_a),
    .i_b   (r_op_b),
    .o_r   (w_mul_r),
    .o_ovf (w_mul_ovf)
  );

  assign bus.ack0     = r_ack0;
  assign bus.ack1     = r_ack1;
  assign bus.done0    = r_done0;
  assign bus.done1    = r_done1;
  assign bus.r        = r_r;
  assign bus.ovf      = r_ovf;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.grant_id = r_grant_id;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=1 instance.
`timescale 1ns/1ps
module tb_mul_share_arbiter;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  mul_share_arbiter_if bus0();
  mul_share_arbiter_if bus1();

  mul_share_arbiter #(.WAIT_CYCLES(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  mul_share_arbiter #(.WAIT_CYCLES(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nclk();
    @(negedge clk);
  endtask

  // {ack0,ack1,done0,done1,busy,grant_id,ovf,r}
  function automatic logic [15:0] outs0();
    return {2'b00, bus0.ack0, bus0.ack1, bus0.done0, bus0.done1, bus0.busy,
            bus0.grant_id, bus0.ovf, bus0.r};
  endfunction

  logic [7:0] exp_r   [2];
  logic       exp_ovf [2];

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_r[0] = 8'hA8; exp_ovf[0] = 1'b1;   // 12*14 = 168
    exp_r[1] = 8'hE2; exp_ovf[1] = 1'b0;   // -2*15 = -30
    bus0.req0 = 0; bus0.a0 = 0; bus0.b0 = 0; bus0.req1 = 0; bus0.a1 = 0; bus0.b1 = 0;
    bus1.req0 = 0; bus1.a0 = 0; bus1.b0 = 0; bus1.req1 = 0; bus1.a1 = 0; bus1.b1 = 0;
    rst_n = 1'b0;
    nclk(); nclk();
    check("reset_outs", outs0(), 16'h0000);
    rst_n = 1'b1;
    nclk();
    check("idle_busy", {15'd0, bus0.busy}, 16'h0000);

    // Single request 7*5
    bus0.req0 = 1; bus0.a0 = 8'd7; bus0.b0 = 8'd5;
    nclk();
    check("t1_ack0", {14'd0, bus0.ack0, bus0.ack1}, 16'h0002);
    check("t1_busy_c1", {15'd0, bus0.busy}, 16'h0001);
    bus0.req0 = 0; bus0.a0 = 8'd0;
    nclk();
    check("t1_c2", {13'd0, bus0.ack0, bus0.done0, bus0.busy}, 16'h0001);
    nclk();
    check("t1_done0", {14'd0, bus0.done0, bus0.done1}, 16'h0002);
    check("t1_r", {7'd0, bus0.ovf, bus0.r}, 16'd35);
    check("t1_busy_c3", {15'd0, bus0.busy}, 16'h0001);
    nclk();
    check("t1_idle", {14'd0, bus0.busy, bus0.done0}, 16'h0000);
    $display("op single: req0 7*5 -> r=%0d ovf=%0d", $signed(bus0.r), bus0.ovf);

    // Simultaneous + fairness from reset: six ops alternating 0,1,0,1,0,1
    rst_n = 1'b0;
    nclk();
    rst_n = 1'b1;
    bus0.req0 = 1; bus0.a0 = 8'd12; bus0.b0 = 8'd14;
    bus0.req1 = 1; bus0.a1 = 8'hFE; bus0.b1 = 8'd15;
    for (int op = 0; op < 6; op++) begin
      logic w;
      w = op[0];
      nclk();
      check($sformatf("fair%0d_ack", op), {14'd0, bus0.ack0, bus0.ack1}, w ? 16'h0001 : 16'h0002);
      check($sformatf("fair%0d_gid", op), {15'd0, bus0.grant_id}, {15'd0, w});
      nclk();
      nclk();
      check($sformatf("fair%0d_done", op),
            {12'd0, bus0.ack0, bus0.ack1, bus0.done0, bus0.done1}, w ? 16'h0001 : 16'h0002);
      check($sformatf("fair%0d_r", op), {7'd0, bus0.ovf, bus0.r}, {7'd0, exp_ovf[w], exp_r[w]});
      $display("op fair%0d: grant=%0d r=%h ovf=%0d", op, bus0.grant_id, bus0.r, bus0.ovf);
      if (op == 5) begin
        bus0.req0 = 0;
        bus0.req1 = 0;
      end
      nclk();
      check($sformatf("fair%0d_gap", op), {15'd0, bus0.busy}, 16'h0000);
    end

    // Operand change after ack: -5*-8 latched, inputs switched to 1,2
    bus0.req1 = 1; bus0.a1 = 8'hFB; bus0.b1 = 8'hF8;
    nclk();
    check("t4_ack1", {14'd0, bus0.ack0, bus0.ack1}, 16'h0001);
    bus0.req1 = 0; bus0.a1 = 8'd1; bus0.b1 = 8'd2;
    nclk();
    nclk();
    check("t4_done1", {14'd0, bus0.done0, bus0.done1}, 16'h0001);
    check("t4_r", {7'd0, bus0.ovf, bus0.r}, 16'd40);
    $display("op chg: req1 -5*-8 -> r=%0d ovf=%0d", $signed(bus0.r), bus0.ovf);
    nclk();

    // Reset during the second EXEC cycle of 15*15
    bus0.req0 = 1; bus0.a0 = 8'd15; bus0.b0 = 8'd15;
    nclk();
    check("t5_ack0", {14'd0, bus0.ack0, bus0.ack1}, 16'h0002);
    bus0.req0 = 0;
    nclk();
    check("t5_exec2_busy", {15'd0, bus0.busy}, 16'h0001);
    rst_n = 1'b0;
    #1;
    check("t5_async_clear", outs0(), 16'h0000);
    nclk();
    check("t5_in_reset", outs0(), 16'h0000);
    rst_n = 1'b1;
    nclk();
    check("t5_no_done", {14'd0, bus0.done0, bus0.busy}, 16'h0000);
    nclk();
    check("t5_no_done2", outs0(), 16'h0000);
    bus0.req1 = 1; bus0.a1 = 8'd1; bus0.b1 = 8'd2;
    nclk();
    check("t5_ack1", {14'd0, bus0.ack0, bus0.ack1}, 16'h0001);
    bus0.req1 = 0;
    nclk();
    nclk();
    check("t5_done1", {14'd0, bus0.done0, bus0.done1}, 16'h0001);
    check("t5_r", {7'd0, bus0.ovf, bus0.r}, 16'd2);
    $display("op rst: req1 1*2 -> r=%0d ovf=%0d", $signed(bus0.r), bus0.ovf);
    nclk();

    // WAIT_CYCLES=1 instance: 11*8, then back-to-back -3*4 three cycles later
    bus1.req1 = 1; bus1.a1 = 8'd11; bus1.b1 = 8'd8;
    nclk();
    check("w1_ack1", {14'd0, bus1.ack0, bus1.ack1}, 16'h0001);
    bus1.req1 = 0;
    nclk();
    check("w1_done1", {13'd0, bus1.ack1, bus1.done0, bus1.done1}, 16'h0001);
    check("w1_r", {7'd0, bus1.ovf, bus1.r}, 16'd88);
    $display("op w1: req1 11*8 -> r=%0d ovf=%0d", $signed(bus1.r), bus1.ovf);
    nclk();
    check("w1_idle", {15'd0, bus1.busy}, 16'h0000);
    bus1.req0 = 1; bus1.a0 = 8'hFD; bus1.b0 = 8'd4;
    nclk();
    check("w1_b2b_ack0", {14'd0, bus1.ack0, bus1.ack1}, 16'h0002);
    bus1.req0 = 0;
    nclk();
    check("w1_b2b_done0", {14'd0, bus1.done0, bus1.done1}, 16'h0002);
    check("w1_b2b_r", {7'd0, bus1.ovf, bus1.r}, 16'h00F4);
    $display("op w1b2b: req0 -3*4 -> r=%0d ovf=%0d", $signed(bus1.r), bus1.ovf);
    nclk();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Time-shares one combinational signed 8x8 multiplier (the `mul_signed` datapath: 8-bit result plus overflow flag) between two requesters.
- Arbitrates round-robin, registers the granted operands, and holds them stable for a programmable settle window.
- Captures the multiplier's result and overflow, then returns them to the winning requester with a one-cycle done pulse.
- Sits between two client FSMs and the shared multiplier instance, which is instantiated inside this block.

Parameters:
- WAIT_CYCLES, 2, number of cycles operands are held at the multiplier before the result is captured; legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0  input  1  requester 0 operation request, level.
- a0  input  8  requester 0 multiplicand, signed two's complement.
- b0  input  8  requester 0 multiplier, signed two's complement.
- req1  input  1  requester 1 operation request, level.
- a1  input  8  requester 1 multiplicand, signed.
- b1  input  8  requester 1 multiplier, signed.
- ack0  output  1  one-cycle pulse: requester 0 operands captured.
- ack1  output  1  one-cycle pulse: requester 1 operands captured.
- done0  output  1  one-cycle pulse: result valid for requester 0.
- done1  output  1  one-cycle pulse: result valid for requester 1.
- r  output  8  signed product, low 8 bits; held until the next capture.
- ovf  output  1  multiplier overflow flag for r; held with r.
- busy  output  1  high while an operation is in flight (EXEC or DONE).
- grant_id  output  1  owner of the current or last operation.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State IDLE.
  - ack0, ack1, done0, done1, busy, r, ovf, grant_id and the operand registers all cleared to 0.
  - Round-robin pointer last_grant set to 1, so requester 0 wins the first tie.
- FSM states are IDLE, EXEC and DONE.
- IDLE:
  - req0 and req1 are sampled only in this state.
  - If neither is high, stay in IDLE.
  - If exactly one is high, grant it.
  - If both are high, grant the requester not equal to last_grant.
  - On the grant edge:
    - Latch the winner's a/b into the operand registers.
    - Set grant_id and last_grant to the winner.
    - Load the counter with WAIT_CYCLES.
    - Go to EXEC. The winner's ack is high for exactly the first EXEC cycle.
- EXEC:
  - Operand registers drive the multiplier unchanged.
  - The counter decrements every edge.
  - On the edge where the counter equals 1, capture the multiplier result into r and its overflow into ovf, then go to DONE.
  - EXEC therefore lasts exactly WAIT_CYCLES cycles.
- DONE:
  - done[grant_id] is high for one cycle; r and ovf are already valid in this cycle.
  - Next edge returns to IDLE.
- Latency:
  - From the grant edge to done rising is WAIT_CYCLES cycles.
  - Throughput is one operation per WAIT_CYCLES+2 cycles.
  - The next grant cannot occur before the IDLE cycle that follows DONE.
- Requester protocol:
  - Hold req and operands stable until ack is seen; deassert req no later than the DONE cycle.
  - A req still high when the FSM re-enters IDLE is treated as a new request.
  - Requests arriving in EXEC or DONE are ignored until IDLE; they are not queued.
  - Operand inputs change freely after ack; the latched operands are unaffected.
- busy is high in EXEC and DONE, low in IDLE.
- Ack/done exclusivity:
  - ack0/ack1 are never high together; done0/done1 are never high together.
  - ack and done never occur in the same cycle.
- Arithmetic and the overflow flag are exactly those of the shared signed multiplier. This block does not post-process the result or the flag.
- Reset mid-operation (in EXEC or DONE):
  - The operation is abandoned; no done pulse is issued.
  - All outputs are cleared as above; last_grant returns to 1.

Test Plan:
- Single request, default WAIT_CYCLES=2: req0 with a0=7, b0=5 → ack0 pulse on the next cycle; done0 two cycles later with r=35, ovf=0; busy high for 3 cycles.
- Simultaneous requests from reset: req0 (12,14) and req1 (-2,15) held high.
  - Requester 0 is served first: r=8'hA8, ovf=1.
  - Requester 1 is served next: r=8'hE2 (-30), ovf=0.
  - No IDLE gap between the two beyond the single IDLE arbitration cycle.
- Fairness: both requests held continuously for 6 operations → grants alternate 0,1,0,1,0,1; each done pulse goes to the matching requester.
- Operand change after ack: a1=-5, b1=-8 captured, then a1/b1 switched to 1,2 during EXEC → done1 with r=40, ovf=0.
- Reset mid-EXEC: pull rst_n low during the second EXEC cycle of (15,15) → all outputs 0 immediately; no done pulse; after release, req1 alone (1,2) gives r=2.
- WAIT_CYCLES=1 build: req1 (11,8) → done1 exactly one cycle after ack1 with r=88, ovf=0; a back-to-back request spaced 3 cycles apart is accepted.
